top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 12 +
 rtl/top_kmap_funcs.sv | 20 ++
 rtl/top.sv | 64 ++++++
 tb/tb_top.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared constants for the four-variable K-map function block.
// Each mask holds f(i) at bit i, where i = {a,b,c,d}.
package top_pkg;

  localparam int NUM_FUNCS = 4;

  localparam logic [15:0] F1_MASK = 16'hA5A5;
  localparam logic [15:0] F2_MASK = 16'h3A3A;
  localparam logic [15:0] F3_MASK = 16'hF3CC;
  localparam logic [15:0] F4_MASK = 16'hACAC;

endpackage

// File: rtl/top_kmap_funcs.sv
// Minimised sum-of-products forms of the four K-map functions.
// Purely combinational; remains valid while the register stage is in reset.
module kmap_funcs (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f1,
  output logic f2,
  output logic f3,
  output logic f4
);

  assign f1 = ~(b ^ d);
  assign f2 = (~b & d) | (b & ~c);
  assign f3 = (a ^ c) | (a & b);
  // BCD prime detector; codes 10..15 are don't-cares folded into the cover
  assign f4 = (~b & c) | (b & d);

endmodule

// File: rtl/top.sv
// K-map function block: combinational f1..f4, a registered snapshot of them,
// and a saturating count of enabled cycles on which f3 was set.
module top
  import top_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
  input  logic                 en,
  input  logic                 clr,
  output logic                 f1,
  output logic                 f2,
  output logic                 f3,
  output logic                 f4,
  output logic [NUM_FUNCS-1:0] fq,
  output logic [CNT_W-1:0]     f3_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 w_f1, w_f2, w_f3, w_f4;
  logic [NUM_FUNCS-1:0] r_fq;
  logic [CNT_W-1:0]     r_f3_cnt;

  kmap_funcs u_funcs (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .f1 (w_f1),
    .f2 (w_f2),
    .f3 (w_f3),
    .f4 (w_f4)
  );

  // clr outranks en; the counter sticks at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fq     <= '0;
      r_f3_cnt <= '0;
    end else if (clr) begin
      r_fq     <= '0;
      r_f3_cnt <= '0;
    end else if (en) begin
      r_fq <= {w_f4, w_f3, w_f2, w_f1};
      if (w_f3 && (r_f3_cnt != CNT_MAX))
        r_f3_cnt <= r_f3_cnt + CNT_ONE;
    end
  end

  assign f1     = w_f1;
  assign f2     = w_f2;
  assign f3     = w_f3;
  assign f4     = w_f4;
  assign fq     = r_fq;
  assign f3_cnt = r_f3_cnt;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: truth-table sweep, reset behaviour, capture,
// clear priority, counter saturation and asynchronous reset mid-count.
module tb_top;

  localparam int CNT_W = 5;

  logic             clk, rst_n, a, b, c, d, en, clr;
  logic             f1, f2, f3, f4;
  logic [3:0]       fq;
  logic [CNT_W-1:0] f3_cnt;
  logic             clk_run;

  int n_chk;
  int n_err;

  // hand-derived truth tables, bit i = f(i)
  logic [15:0] exp_f1, exp_f2, exp_f3, exp_f4;

  top #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .en     (en),
    .clr    (clr),
    .f1     (f1),
    .f2     (f2),
    .f3     (f3),
    .f4     (f4),
    .fq     (fq),
    .f3_cnt (f3_cnt)
  );

  initial clk = 1'b0;
  always begin
    #5;
    clk = clk_run ? ~clk : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idx(input logic [3:0] i);
    {a, b, c, d} = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_f1 = 16'b1010_0101_1010_0101;
    exp_f2 = 16'b0011_1010_0011_1010;
    exp_f3 = 16'b1111_0011_1100_1100;
    exp_f4 = 16'b1010_1100_1010_1100;
    clk_run = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    set_idx(4'd0);
    #10;
    chk("reset_fq", fq, 0);
    chk("reset_cnt", f3_cnt, 0);

    // combinational sweep, no clock
    for (int i = 0; i < 16; i++) begin
      set_idx(i[3:0]);
      #10;
      chk($sformatf("sweep_f1[%0d]", i), f1, exp_f1[i]);
      chk($sformatf("sweep_f2[%0d]", i), f2, exp_f2[i]);
      chk($sformatf("sweep_f3[%0d]", i), f3, exp_f3[i]);
      chk($sformatf("sweep_f4[%0d]", i), f4, exp_f4[i]);
    end

    // clocked with reset held: registers stay cleared, f3 tracks inputs
    clk_run = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_idx((k % 2 == 0) ? 4'd15 : 4'd9);
      tick();
      chk("rst_hold_fq", fq, 0);
      chk("rst_hold_cnt", f3_cnt, 0);
      chk("rst_hold_f3", f3, 1);
    end
    set_idx(4'd4);
    #1;
    chk("rst_hold_f3_low", f3, 0);

    // release between edges
    en = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_fq", fq, 0);

    en = 1'b1;
    set_idx(4'd9);
    tick();
    chk("cap9_fq", fq, 4'b0110);
    chk("cap9_cnt", f3_cnt, 1);
    set_idx(4'd4);
    tick();
    chk("cap4_fq", fq, 4'b0010);
    chk("cap4_cnt", f3_cnt, 1);

    en = 1'b0;
    set_idx(4'd15);
    tick();
    chk("hold_fq", fq, 4'b0010);
    chk("hold_cnt", f3_cnt, 1);

    en = 1'b1;
    clr = 1'b1;
    tick();
    chk("clr_pri_fq", fq, 0);
    chk("clr_pri_cnt", f3_cnt, 0);

    // saturation: i=15 gives {f4,f3,f2,f1}=1101
    clr = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("sat_cnt[%0d]", k), f3_cnt, (k > 31) ? 31 : k);
    end
    chk("sat_fq", fq, 4'b1101);

    clr = 1'b1;
    tick();
    chk("clr_cnt", f3_cnt, 0);
    clr = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("pre_async_cnt", f3_cnt, 7);

    // async reset between edges
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_cnt", f3_cnt, 0);
    chk("async_fq", fq, 0);
    chk("async_f3", f3, 1);

    clk_run = 1'b0;
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
